// File: rtl/shift_deserializer_pkg.sv
// Shared encodings for the serial-to-parallel word assembler.
package shift_deserializer_pkg;

  typedef enum logic [1:0] {
    MODE_MSB   = 2'b00,
    MODE_LSB_Z = 2'b01,
    MODE_LSB_S = 2'b10
  } mode_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PAD     = 1'b1
  } state_t;

  // The unused encoding 2'b11 behaves as MSB-first.
  function automatic mode_t norm_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_LSB_Z;
      2'b10:   return MODE_LSB_S;
      default: return MODE_MSB;
    endcase
  endfunction

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial bit input and assembled-word output of shift_deserializer.
interface shift_deserializer_if #(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1)
);
  logic [1:0]    mode;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic          flush;
  logic [W-1:0]  out_word;
  logic [CW-1:0] out_len;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output mode, bit_in, bit_valid, flush, out_ready,
    input  bit_ready, out_word, out_len, out_valid
  );

  modport slave (
    input  mode, bit_in, bit_valid, flush, out_ready,
    output bit_ready, out_word, out_len, out_valid
  );
endinterface

// File: rtl/deser_out_reg.sv
// One-entry valid/ready holding register for assembled words.
module deser_out_reg #(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [W-1:0]  load_word,
  input  logic [CW-1:0] load_len,
  input  logic          out_ready,
  output logic          free,
  output logic          out_valid,
  output logic [W-1:0]  out_word,
  output logic [CW-1:0] out_len
);

  assign free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_len   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_word  <= load_word;
      out_len   <= load_len;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Shifts one bit per handshake into a W-bit word; flush closes a partial word.
//   state      | meaning
//   ST_COLLECT | accepting bits, handing full words to the output register
//   ST_PAD     | right-aligning an LSB-first partial word, one bit per cycle
module shift_deserializer
  import shift_deserializer_pkg::*;
#(
  parameter  int W  = 16,
  localparam int CW = $clog2(W + 1)
) (
  input logic                 clk,
  input logic                 reset_n,
  shift_deserializer_if.slave bus
);

  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state, state_n;
  mode_t         mode_q, mode_n, mode_eff;
  logic [W-1:0]  sr, sr_n, sr_base;
  logic [CW-1:0] cnt, cnt_n, cnt_base, len_q, len_n;
  logic          lastbit, lastbit_n;
  logic          acc, xfer, out_free, full, fill, flush_lsb;

  assign full = (cnt == CNT_FULL);
  assign xfer = full && out_free;
  assign acc  = bus.bit_valid && bus.bit_ready;
  assign fill = (mode_q == MODE_LSB_S) && lastbit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_COLLECT;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_COLLECT: if (flush_lsb) state_n = ST_PAD;
      ST_PAD:     if (cnt + CNT_ONE == CNT_FULL) state_n = ST_COLLECT;
      default:    state_n = ST_COLLECT;
    endcase
  end

  always_comb begin
    bus.bit_ready = (state == ST_COLLECT) && (!full || out_free);
  end

  // A bit arriving with a transfer starts the next word from a cleared register.
  always_comb begin
    sr_base   = xfer ? '0 : sr;
    cnt_base  = xfer ? '0 : cnt;
    mode_eff  = (cnt_base == '0) ? norm_mode(bus.mode) : mode_q;
    sr_n      = sr_base;
    cnt_n     = cnt_base;
    mode_n    = mode_q;
    lastbit_n = lastbit;
    len_n     = xfer ? CNT_FULL : len_q;
    flush_lsb = 1'b0;
    if (state == ST_PAD) begin
      sr_n  = {fill, sr[W-1:1]};
      cnt_n = cnt + CNT_ONE;
    end else begin
      if (acc) begin
        mode_n    = mode_eff;
        sr_n      = (mode_eff == MODE_MSB) ? {sr_base[W-2:0], bus.bit_in}
                                           : {bus.bit_in, sr_base[W-1:1]};
        cnt_n     = cnt_base + CNT_ONE;
        lastbit_n = bus.bit_in;
      end
      if (bus.flush && (cnt_n != '0) && (cnt_n != CNT_FULL)) begin
        len_n = cnt_n;
        if (mode_n == MODE_MSB) cnt_n = CNT_FULL;
        else                    flush_lsb = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr      <= '0;
      cnt     <= '0;
      len_q   <= CNT_FULL;
      lastbit <= 1'b0;
      mode_q  <= MODE_MSB;
    end else begin
      sr      <= sr_n;
      cnt     <= cnt_n;
      len_q   <= len_n;
      lastbit <= lastbit_n;
      mode_q  <= mode_n;
    end
  end

  deser_out_reg #(.W(W), .CW(CW)) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (xfer),
    .load_word (sr),
    .load_len  (len_q),
    .out_ready (bus.out_ready),
    .free      (out_free),
    .out_valid (bus.out_valid),
    .out_word  (bus.out_word),
    .out_len   (bus.out_len)
  );

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: directed scenarios plus random traffic against a bit-list model.
module tb_shift_deserializer;
  parameter int W = 16;

  typedef struct {
    logic [W-1:0] word;
    int           len;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  bit         mbits[$];
  logic [1:0] mmode = 2'b00;
  int         pad_left = 0;
  exp_t       expq[$];
  bit         last_acc = 1'b0;
  bit         last_valid = 1'b0;
  int         lat;

  always #5 clk = ~clk;

  shift_deserializer_if #(.W(W)) bus ();

  shift_deserializer #(.W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Closed word from the list of received bits; LSB-first words get padded above.
  function automatic void finalize_word();
    exp_t e;
    int   n;
    n = mbits.size();
    e.word = '0;
    e.len  = n;
    if (mmode == 2'b00) begin
      for (int i = 0; i < n; i++) e.word[n-1-i] = mbits[i];
    end else begin
      for (int i = 0; i < W; i++)
        e.word[i] = (i < n) ? mbits[i] : ((mmode == 2'b10) && mbits[n-1]);
      if (n < W) pad_left = W - n;
    end
    expq.push_back(e);
    mbits.delete();
  endfunction

  task automatic monitor();
    bit in_pad;
    in_pad = (pad_left > 0);
    if (in_pad) begin
      check_eq("pad_bit_ready", 32'(bus.bit_ready), 32'(0));
      pad_left--;
    end
    last_valid = bus.out_valid;
    if (bus.out_valid) begin
      if (expq.size() == 0) begin
        check_eq("spurious_valid", 32'(bus.out_valid), 32'(0));
      end else begin
        check_eq("out_word", 32'(bus.out_word), 32'(expq[0].word));
        check_eq("out_len", 32'(bus.out_len), expq[0].len);
        if (bus.out_ready) void'(expq.pop_front());
      end
    end
    last_acc = bus.bit_valid && bus.bit_ready;
    if (last_acc) begin
      if (mbits.size() == 0) mmode = (bus.mode == 2'b11) ? 2'b00 : bus.mode;
      mbits.push_back(bus.bit_in);
      if (mbits.size() == W) finalize_word();
    end
    if (bus.flush && !in_pad && mbits.size() > 0) finalize_word();
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_bit(input bit b);
    int n;
    n = 0;
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!last_acc && n < 200);
    check_eq("bit_accept", 32'(last_acc), 32'(1));
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] v, input int n, input logic [1:0] m);
    bus.mode = m;
    for (int i = 0; i < n; i++)
      send_bit((m == 2'b00 || m == 2'b11) ? v[n-1-i] : v[i]);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    bus.bit_valid = 1'b0;
    bus.flush     = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'(0));
    check_eq({tag, "_word"}, 32'(bus.out_word), 32'(0));
    check_eq({tag, "_len"}, 32'(bus.out_len), 32'(0));
    check_eq({tag, "_ready"}, 32'(bus.bit_ready), 32'(1));
    mbits.delete();
    expq.delete();
    pad_left = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.mode      = 2'b00;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    apply_reset("rst_init");
    step();

    // MSB-first word, output visible one cycle after the last accepted bit
    send_word(W'(16'hA5C3), W, 2'b00);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!last_valid && lat < 20);
    check_eq("msb_latency", lat, 2);
    idle(2);

    // LSB-first zero-fill, back-to-back words
    send_word(W'(16'h1234), W, 2'b01);
    send_word(W'(16'hBEEF), W, 2'b01);
    idle(4);
    check_eq("lsb_b2b_drained", expq.size(), 0);

    // Partial LSB-first words: sign-fill then zero-fill
    send_word(W'(4'b1101), 4, 2'b10);
    do_flush();
    idle(W + 2);
    send_word(W'(4'b1101), 4, 2'b01);
    do_flush();
    idle(W + 2);
    check_eq("pad_drained", expq.size(), 0);

    // Backpressure: two words held, third bit stream stalls
    bus.out_ready = 1'b0;
    send_word(W'(16'h1111), W, 2'b00);
    send_word(W'(16'h2222), W, 2'b00);
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    step();
    check_eq("full_bit_ready", 32'(bus.bit_ready), 32'(0));
    idle(3);
    bus.bit_valid = 1'b0;
    bus.out_ready = 1'b1;
    idle(4);
    check_eq("bp_drained", expq.size(), 0);

    // MSB-first flush of 3 bits, then a flush with nothing collected
    send_word(W'(3'b110), 3, 2'b00);
    do_flush();
    idle(3);
    do_flush();
    idle(3);
    check_eq("empty_flush", 32'(last_valid), 32'(0));

    // Reset with a pending output and a partial word, then during PAD
    bus.out_ready = 1'b0;
    send_word(W'(16'h5A5A), W, 2'b00);
    send_word(W'(7'h55), 7, 2'b00);
    apply_reset("rst_word");
    bus.out_ready = 1'b1;
    send_word(W'(3'b101), 3, 2'b01);
    do_flush();
    idle(2);
    apply_reset("rst_pad");
    send_word(W'(16'h00FF), W, 2'b00);
    idle(4);
    check_eq("post_reset_drained", expq.size(), 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.bit_valid = ($urandom_range(0, 3) != 0);
      bus.bit_in    = 1'($urandom);
      bus.mode      = 2'($urandom);
      bus.flush     = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.bit_valid = 1'b0;
    bus.out_ready = 1'b1;
    do_flush();
    idle(2 * W + 8);
    check_eq("rand_drained", expq.size(), 0);
    check_eq("rand_open_bits", mbits.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
